// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV multi-cycle core: opcodes, ALU operations, FSM states.
package rv_core_pkg;

    localparam logic [6:0]  OP_R       = 7'b0110011;
    localparam logic [6:0]  OP_I       = 7'b0010011;
    localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

    // SUB exists only in the register form; ADDI with ir[30] set is still an add.
    function automatic alu_op_t decode_alu_op(input logic [31:0] ir);
        alu_op_t op;
        op = ALU_ADD;
        case (ir[14:12])
            3'b000: op = ((ir[6:0] == OP_R) && ir[30]) ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = ir[30] ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            3'b111: op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU for the RV multi-cycle core, XLEN-wide.
module rv_alu
    import rv_core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result
);

    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: result = XLEN'(a < b);
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = XLEN'($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32/RV64 integer core: FETCH/DECODE/EXECUTE/WRITEBACK FSM with inline register file.
// Optional retired-instruction counter enabled by defining RV_INSTR_COUNT_EN.
module rv_multicycle_core
    import rv_core_pkg::*;
#(
    parameter int unsigned         XLEN     = 32,
    parameter int unsigned         NREGS    = 32,
    parameter int unsigned         PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_valid,
    input  logic [31:0]         imem_rdata,
    output logic                zero,
    output logic                retired,
    output logic                halted,
    output logic [31:0]         instr_count
);

    localparam int unsigned IDX_W = $clog2(NREGS);

    state_t                state;
    state_t                state_next;
    logic                  boot;
    logic [PC_WIDTH-1:0]   pc;
    logic [31:0]           ir;
    logic [XLEN-1:0]       regs [NREGS];
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       alu_y;
    alu_op_t               alu_op;
    logic                  is_alu;

    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [6:0]            opcode;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       rs1_val;
    logic [XLEN-1:0]       rs2_val;
    logic                  rd_ok;

    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign rd        = ir[11:7];
    assign opcode    = ir[6:0];
    assign imm       = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imem_addr = pc;
    assign rd_ok     = (rd != 5'd0) && ({1'b0, rd} < 6'(NREGS));

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if ((rs1 != 5'd0) && ({1'b0, rs1} < 6'(NREGS)))
            rs1_val = regs[rs1[IDX_W-1:0]];
        if ((rs2 != 5'd0) && ({1'b0, rs2} < 6'(NREGS)))
            rs2_val = regs[rs2[IDX_W-1:0]];
    end

    rv_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (alu_op),
        .result (alu_y)
    );

    // The first FETCH cycle after reset keeps imem_req low so outputs show reset values.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        retired    = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = !boot;
                if (!boot && imem_valid)
                    state_next = ST_DECODE;
            end
            ST_DECODE:    state_next = ST_EXECUTE;
            ST_EXECUTE:   state_next = (ir == ECALL_WORD) ? ST_HALT : ST_WRITEBACK;
            ST_WRITEBACK: begin
                retired    = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT:      halted = 1'b1;
            default:      state_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_FETCH;
            boot   <= 1'b1;
            pc     <= RESET_PC;
            ir     <= '0;
            op_a   <= '0;
            op_b   <= '0;
            result <= '0;
            alu_op <= ALU_ADD;
            is_alu <= 1'b0;
            zero   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else begin
            state <= state_next;
            boot  <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (imem_req && imem_valid)
                        ir <= imem_rdata;
                end
                ST_DECODE: begin
                    op_a   <= rs1_val;
                    op_b   <= (opcode == OP_R) ? rs2_val : imm;
                    alu_op <= decode_alu_op(ir);
                    is_alu <= (opcode == OP_R) || (opcode == OP_I);
                end
                ST_EXECUTE: result <= alu_y;
                ST_WRITEBACK: begin
                    if (is_alu && rd_ok) begin
                        regs[rd[IDX_W-1:0]] <= result;
                        zero                <= (result == '0);
                    end
                    pc <= pc + PC_WIDTH'(4);
                end
                default: ;
            endcase
        end
    end

`ifdef RV_INSTR_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else if (retired)
            count_q <= count_q + 32'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = '0;
`endif

endmodule
